// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Latency: n/a (types only).
// Backpressure: n/a.
package fetch_pkg;

  // Bytes per instruction word and the PC read-ahead the register file sees.
  localparam logic [31:0] INSTR_BYTES   = 32'd4;
  localparam logic [31:0] PC_READ_AHEAD = 32'd8;
  localparam int          FIFO_DEPTH    = 2;

  // One instruction-buffer entry: the fetched word and its byte address.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction memory port, redirect input, decode handshake.
// Latency: n/a (wiring only).
// Backpressure: out_ready from the consumer; imem has no backpressure.
// Ports: master = fetch stage side, slave = memory/decode/branch side.
interface fetch_stage_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus8;

  modport master (
    output imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc_plus8,
    input  imem_rdata, branch_taken, branch_target, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc_plus8,
    output imem_rdata, branch_taken, branch_target, out_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Two-entry instruction buffer of fetch_entry_t with flush.
// Latency: a push is visible at the head the following cycle.
// Backpressure: caller must not push when full without a pop; guarded here anyway.
// Ports: clk, reset (sync, active-low), push_i/push_dat_i, pop_i, flush_i,
//        head_dat_o (oldest entry), count_o (occupancy 0..2).
module fetch_fifo
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  fetch_entry_t push_dat_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output fetch_entry_t head_dat_o,
  output logic [1:0]   count_o
);

  fetch_entry_t mem_q [FIFO_DEPTH];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push, do_pop;

  // Never pop empty, never push full unless the same cycle frees a slot.
  assign do_pop  = pop_i && (count_q != 2'd0);
  assign do_push = push_i && ((count_q != 2'd2) || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) wr_ptr_d = ~wr_ptr_q;
      if (do_pop)  rd_ptr_d = ~rd_ptr_q;
      if (do_push && !do_pop)      count_d = count_q + 2'd1;
      else if (!do_push && do_pop) count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count qualifies every read.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign head_dat_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, one-deep in-flight tracking, issue control, 2-entry buffer.
// Latency: req in cycle 0, data in cycle 1, out_valid in cycle 2; one instr/cycle.
// Backpressure: out_ready=0 stalls issue once buffer+in-flight reaches depth.
// Ports: clk, reset (sync, active-low), bus (fetch_stage_if.master).
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic           clk,
  input  logic           reset,
  fetch_stage_if.master  bus
);

  localparam logic [2:0] DEPTH_L = 3'(BUF_DEPTH);

  logic [31:0]  pc_q, pc_d;
  logic         inflight_q, inflight_d;
  logic [31:0]  inflight_pc_q, inflight_pc_d;
  logic [1:0]   count;
  fetch_entry_t head_dat, push_dat;
  logic         out_vld, pop, push, issue;
  logic [2:0]   occ_after_pop;
  logic [31:0]  target_aligned;

  // Outputs are forced quiet while reset is held, even if state is still stale.
  assign out_vld = reset && (count != 2'd0);
  // A redirect cancels the pop: the head is being flushed, not consumed.
  assign pop     = out_vld && bus.out_ready && !bus.branch_taken;
  // Slots committed after this cycle's pop; issue only if one stays free.
  assign occ_after_pop = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue   = reset && !bus.branch_taken && (occ_after_pop < DEPTH_L);
  // A redirect squashes the returning word.
  assign push    = reset && inflight_q && !bus.branch_taken;

  assign target_aligned = bus.branch_target & ~32'h0000_0003;
  assign push_dat       = '{instr: bus.imem_rdata, pc: inflight_pc_q};

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    if (bus.branch_taken) pc_d = target_aligned;
    else if (issue)       pc_d = pc_q + INSTR_BYTES;
    if (issue) inflight_pc_d = pc_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'd0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_fifo u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (push),
    .push_dat_i (push_dat),
    .pop_i      (pop),
    .flush_i    (bus.branch_taken),
    .head_dat_o (head_dat),
    .count_o    (count)
  );

  assign bus.imem_req     = issue;
  assign bus.imem_addr    = pc_q;
  assign bus.out_valid    = out_vld;
  assign bus.out_instr    = out_vld ? head_dat.instr : 32'd0;
  assign bus.out_pc       = out_vld ? head_dat.pc    : 32'd0;
  assign bus.out_pc_plus8 = bus.out_pc + PC_READ_AHEAD;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: queue-based reference model plus directed literal checks.
module tb_fetch_stage;

  logic clk;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  fetch_stage_if b1 ();
  fetch_stage_if b2 ();

  fetch_stage #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .bus(b1)
  );
  fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(2)) dut_wrap (
    .clk(clk), .reset(reset), .bus(b2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Instruction memory: answers the cycle after each request.
  initial begin
    logic r1, r2;
    logic [31:0] a1, a2;
    b1.imem_rdata = 32'd0;
    b2.imem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      r1 = b1.imem_req; a1 = b1.imem_addr;
      r2 = b2.imem_req; a2 = b2.imem_addr;
      @(posedge clk);
      #1;
      b1.imem_rdata = r1 ? word(a1) : $urandom();
      b2.imem_rdata = r2 ? word(a2) : $urandom();
    end
  end

  // Reference model: queue of issued-but-undelivered fetches, each with the
  // cycle from which it may appear at the output.
  typedef struct {
    logic [31:0] pc;
    int          rdy;
  } ment_t;

  initial begin
    ment_t       q[$];
    logic [31:0] m_pc = 32'd0;
    int          cyc = 0;
    logic        e_valid, e_pop, e_req, r, b;
    logic [31:0] t, e_pc, e_instr;
    forever begin
      @(negedge clk);
      e_valid = reset && (q.size() > 0) && (q[0].rdy <= cyc);
      e_pop   = e_valid && b1.out_ready && !b1.branch_taken;
      e_req   = reset && !b1.branch_taken && ((q.size() - (e_pop ? 1 : 0)) < 2);
      e_pc    = e_valid ? q[0].pc : 32'd0;
      e_instr = e_valid ? word(q[0].pc) : 32'd0;
      chk($sformatf("model imem_req c%0d", cyc), 32'(b1.imem_req), 32'(e_req));
      if (e_req) chk($sformatf("model imem_addr c%0d", cyc), b1.imem_addr, m_pc);
      chk($sformatf("model out_valid c%0d", cyc), 32'(b1.out_valid), 32'(e_valid));
      chk($sformatf("model out_pc c%0d", cyc), b1.out_pc, e_pc);
      chk($sformatf("model out_instr c%0d", cyc), b1.out_instr, e_instr);
      chk($sformatf("model out_pc_plus8 c%0d", cyc), b1.out_pc_plus8, e_pc + 32'd8);
      r = reset; b = b1.branch_taken; t = b1.branch_target;
      @(posedge clk);
      cyc++;
      if (!r) begin
        q.delete();
        m_pc = 32'h0000_0000;
      end else if (b) begin
        q.delete();
        m_pc = {t[31:2], 2'b00};
      end else begin
        if (e_pop) void'(q.pop_front());
        if (e_req) begin
          q.push_back('{pc: m_pc, rdy: cyc + 1});
          m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Holds reset low across two edges; returns at the start of cycle 0.
  task automatic do_reset();
    reset = 1'b0;
    next_cycle();
    next_cycle();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    b1.out_ready = 1'b0;
    b1.branch_taken = 1'b0;
    b1.branch_target = 32'd0;
    b2.out_ready = 1'b1;
    b2.branch_taken = 1'b0;
    b2.branch_target = 32'd0;
    repeat (3) next_cycle();

    // Reset state.
    @(negedge clk);
    chk("rst imem_req", 32'(b1.imem_req), 32'd0);
    chk("rst out_valid", 32'(b1.out_valid), 32'd0);
    chk("rst out_pc", b1.out_pc, 32'd0);
    chk("rst out_instr", b1.out_instr, 32'd0);
    chk("rst out_pc_plus8", b1.out_pc_plus8, 32'd8);

    // Streaming from reset, plus wrap-around instance.
    next_cycle();
    reset = 1'b1;
    b1.out_ready = 1'b1;
    @(negedge clk);
    chk("A c0 imem_req", 32'(b1.imem_req), 32'd1);
    chk("A c0 imem_addr", b1.imem_addr, 32'd0);
    chk("W c0 imem_addr", b2.imem_addr, 32'hFFFF_FFF8);
    next_cycle();
    @(negedge clk);
    chk("A c1 out_valid", 32'(b1.out_valid), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("A c2 out_valid", 32'(b1.out_valid), 32'd1);
    chk("A c2 out_pc", b1.out_pc, 32'd0);
    chk("A c2 out_instr", b1.out_instr, 32'hA5A5_0000);
    chk("W c2 out_pc", b2.out_pc, 32'hFFFF_FFF8);
    next_cycle();
    @(negedge clk);
    chk("A c3 out_pc", b1.out_pc, 32'd4);
    chk("W c3 out_pc", b2.out_pc, 32'hFFFF_FFFC);
    chk("W c3 out_pc_plus8", b2.out_pc_plus8, 32'd4);
    next_cycle();
    @(negedge clk);
    chk("A c4 out_pc", b1.out_pc, 32'd8);
    chk("A c4 out_pc_plus8", b1.out_pc_plus8, 32'd16);
    chk("A c4 out_instr", b1.out_instr, 32'hA5A5_0008);
    chk("W c4 out_pc", b2.out_pc, 32'd0);

    // Backpressure: buffer saturates, head stable, then resumes in order.
    next_cycle();
    do_reset();
    b1.out_ready = 1'b0;
    repeat (5) next_cycle();
    @(negedge clk);
    chk("B c5 out_valid", 32'(b1.out_valid), 32'd1);
    chk("B c5 out_pc", b1.out_pc, 32'd0);
    chk("B c5 out_instr", b1.out_instr, 32'hA5A5_0000);
    chk("B c5 imem_req", 32'(b1.imem_req), 32'd0);
    next_cycle();
    b1.out_ready = 1'b1;
    @(negedge clk);
    chk("B c6 out_pc", b1.out_pc, 32'd0);
    next_cycle();
    @(negedge clk);
    chk("B c7 out_pc", b1.out_pc, 32'd4);
    next_cycle();
    @(negedge clk);
    chk("B c8 out_pc", b1.out_pc, 32'd8);
    chk("B c8 out_valid", 32'(b1.out_valid), 32'd1);

    // Redirect at cycle 6 to an unaligned target.
    next_cycle();
    do_reset();
    repeat (6) next_cycle();
    b1.branch_taken = 1'b1;
    b1.branch_target = 32'h0000_0103;
    @(negedge clk);
    chk("C c6 imem_req", 32'(b1.imem_req), 32'd0);
    next_cycle();
    b1.branch_taken = 1'b0;
    @(negedge clk);
    chk("C c7 imem_req", 32'(b1.imem_req), 32'd1);
    chk("C c7 imem_addr", b1.imem_addr, 32'h0000_0100);
    chk("C c7 out_valid", 32'(b1.out_valid), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("C c8 out_valid", 32'(b1.out_valid), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("C c9 out_valid", 32'(b1.out_valid), 32'd1);
    chk("C c9 out_pc", b1.out_pc, 32'h0000_0100);
    chk("C c9 out_instr", b1.out_instr, 32'hA5A5_0100);

    // One-cycle reset with a full buffer.
    next_cycle();
    b1.out_ready = 1'b0;
    repeat (4) next_cycle();
    reset = 1'b0;
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    chk("D r0 out_valid", 32'(b1.out_valid), 32'd0);
    chk("D r0 imem_addr", b1.imem_addr, 32'd0);
    chk("D r0 imem_req", 32'(b1.imem_req), 32'd1);
    next_cycle();
    @(negedge clk);
    chk("D r1 out_valid", 32'(b1.out_valid), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("D r2 out_valid", 32'(b1.out_valid), 32'd1);
    chk("D r2 out_pc", b1.out_pc, 32'd0);

    // Randomized traffic; the model process checks every cycle.
    for (int i = 0; i < 4000; i++) begin
      next_cycle();
      b1.out_ready = ($urandom_range(0, 3) != 0);
      b1.branch_taken = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 3))
        0:       b1.branch_target = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: b1.branch_target = $urandom();
      endcase
      reset = ($urandom_range(0, 63) != 0);
    end
    next_cycle();
    reset = 1'b1;
    b1.branch_taken = 1'b0;
    b1.out_ready = 1'b1;
    repeat (5) next_cycle();
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
